// File: rtl/calc_sequencer_p.sv
// rtl/calc_sequencer_p.sv - calculator operand entry and operation dispatch sequencer
//
// Builds signed decimal operands A and B from keypad codes. Entry supports a digit
// limit, backspace and sign toggle. The sequencer then starts one of NOPS external
// arithmetic units and waits, under a watchdog, for its result. It range-checks the
// result and shows it, and the result can be chained as the next A.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_valid/key_code  keypad strobe and code (0-9 digits, 10 enter, 11-17 ops,
//                       18 escape, 19 backspace, 20 negate, others ignored)
//   op_sel/op_start     one-hot unit select (bit0 sqrt .. bit6 plus) and start pulse
//   operand_a/operand_b signed operands presented to the unit
//   res_valid/res_data/res_err  result handshake from the selected unit
//   display             value to show (A, B or the latched result)
//   overflow/error/busy status flags; state exposes the current state code
module calc_sequencer_p #(
  parameter int DIGITS = 8,
  parameter int W      = 28,
  parameter int HOLD_W = 23,
  parameter int TMO_W  = 16,
  parameter int NOPS   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  output logic [NOPS-1:0]     op_sel,
  output logic                op_start,
  output logic signed [W-1:0] operand_a,
  output logic signed [W-1:0] operand_b,
  input  logic                res_valid,
  input  logic signed [W-1:0] res_data,
  input  logic                res_err,
  output logic signed [W-1:0] display,
  output logic                overflow,
  output logic                error,
  output logic                busy,
  output logic [3:0]          state
);

  localparam logic signed [W-1:0] MAXV = W'(10**DIGITS - 1);
  localparam logic signed [W-1:0] TEN  = W'(10);
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [4:0] K_ENTER = 5'd10;
  localparam logic [4:0] K_ESC   = 5'd18;
  localparam logic [4:0] K_BACK  = 5'd19;
  localparam logic [4:0] K_NEG   = 5'd20;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ENTRY_A  = 4'd1,
    S_HOLD_A   = 4'd2,
    S_ENTRY_B  = 4'd3,
    S_HOLD_B   = 4'd4,
    S_DISPATCH = 4'd5,
    S_WAIT_RES = 4'd6,
    S_SHOW     = 4'd7,
    S_ERROR    = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [CW-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [NOPS-1:0]     op_sel_q, op_sel_d;
  logic                ovf_q, ovf_d;
  logic [HOLD_W:0]     hold_q, hold_d;
  logic [TMO_W:0]      wd_q, wd_d;

  // Key classification
  logic                is_digit, is_bin, is_un, is_esc;
  logic signed [W-1:0] dig;
  logic [NOPS-1:0]     key_onehot;

  always_comb begin
    is_digit   = key_valid && (key_code <= 5'd9);
    is_esc     = key_valid && (key_code == K_ESC);
    is_bin     = key_valid && ((key_code >= 5'd11 && key_code <= 5'd14) || key_code == 5'd16);
    is_un      = key_valid && (key_code == 5'd15 || key_code == 5'd17);
    dig        = $signed(W'(key_code));
    // Operator codes 11..17 map to bits 6..0 (plus is the top bit, sqrt bit 0).
    key_onehot = '0;
    for (int i = 0; i < NOPS; i++) begin
      if (int'(key_code) == 17 - i) key_onehot[i] = 1'b1;
    end
  end

  // Edit of the operand currently being entered (A, or B in ENTRY_B).
  logic signed [W-1:0] cur_val, ed_val;
  logic [CW-1:0]       cur_cnt, ed_cnt;
  logic                ed_hold;

  always_comb begin
    cur_val = (state_q == S_ENTRY_B) ? b_q : a_q;
    cur_cnt = (state_q == S_ENTRY_B) ? cnt_b_q : cnt_a_q;
    ed_val  = cur_val;
    ed_cnt  = cur_cnt;
    ed_hold = 1'b0;
    if (is_digit) begin
      if (cur_cnt < CW'(DIGITS)) begin
        // New digit extends the magnitude, so it carries the operand's sign.
        ed_val  = cur_val[W-1] ? (cur_val * TEN - dig) : (cur_val * TEN + dig);
        ed_hold = 1'b1;
        // Leading zeros do not consume digit positions.
        if (!(cur_val == '0 && dig == '0)) ed_cnt = cur_cnt + 1'b1;
      end
    end else if (key_valid && key_code == K_BACK) begin
      ed_val = cur_val / TEN;
      if (cur_cnt != '0) ed_cnt = cur_cnt - 1'b1;
    end else if (key_valid && key_code == K_NEG) begin
      ed_val = -cur_val;
    end
  end

  logic res_bad;
  assign res_bad = res_err || (res_data > MAXV) || (res_data < -MAXV);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    disp_d   = disp_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_sel_d = op_sel_q;
    ovf_d    = ovf_q;
    hold_d   = hold_q;
    wd_d     = wd_q;
    // Escape and IDLE both wipe the session so the display and flags clear at once.
    if (is_esc || state_q == S_IDLE) begin
      state_d  = is_esc ? S_IDLE : S_ENTRY_A;
      a_d      = '0;
      b_d      = '0;
      disp_d   = '0;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      op_sel_d = '0;
      ovf_d    = 1'b0;
      hold_d   = '0;
      wd_d     = '0;
    end else begin
      case (state_q)
        S_ENTRY_A: begin
          if (is_bin) begin
            op_sel_d = key_onehot;
            b_d      = '0;
            cnt_b_d  = '0;
            state_d  = S_ENTRY_B;
          end else if (is_un) begin
            op_sel_d = key_onehot;
            state_d  = S_DISPATCH;
          end else begin
            a_d     = ed_val;
            cnt_a_d = ed_cnt;
            if (ed_hold) begin
              hold_d  = '0;
              state_d = S_HOLD_A;
            end
          end
        end
        S_ENTRY_B: begin
          if (key_valid && key_code == K_ENTER) begin
            state_d = S_DISPATCH;
          end else if (!is_bin && !is_un) begin
            b_d     = ed_val;
            cnt_b_d = ed_cnt;
            if (ed_hold) begin
              hold_d  = '0;
              state_d = S_HOLD_B;
            end
          end
        end
        S_HOLD_A, S_HOLD_B: begin
          // Leave on the increment that sets the MSB: exactly 2^HOLD_W cycles.
          hold_d = hold_q + 1'b1;
          if (hold_d[HOLD_W]) state_d = (state_q == S_HOLD_A) ? S_ENTRY_A : S_ENTRY_B;
        end
        S_DISPATCH: begin
          wd_d    = '0;
          state_d = S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (res_valid) begin
            disp_d = res_data;
            if (res_bad) begin
              ovf_d   = 1'b1;
              state_d = S_ERROR;
            end else begin
              state_d = S_SHOW;
            end
          end else begin
            wd_d = wd_q + 1'b1;
            if (wd_d[TMO_W]) begin
              ovf_d   = 1'b1;
              state_d = S_ERROR;
            end
          end
        end
        S_SHOW: begin
          if (is_digit) begin
            a_d     = dig;
            cnt_a_d = CW'(1);
            b_d     = '0;
            cnt_b_d = '0;
            hold_d  = '0;
            state_d = S_HOLD_A;
          end else if (is_bin) begin
            a_d      = disp_q;
            cnt_a_d  = CW'(DIGITS);
            b_d      = '0;
            cnt_b_d  = '0;
            op_sel_d = key_onehot;
            state_d  = S_ENTRY_B;
          end else if (is_un) begin
            a_d      = disp_q;
            op_sel_d = key_onehot;
            state_d  = S_DISPATCH;
          end
        end
        S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      disp_q   <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      op_sel_q <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      disp_q   <= disp_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      op_sel_q <= op_sel_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    case (state_q)
      S_ENTRY_A, S_HOLD_A: display = a_q;
      S_ENTRY_B, S_HOLD_B: display = b_q;
      default:             display = disp_q;
    endcase
  end

  assign op_sel    = op_sel_q;
  assign op_start  = (state_q == S_DISPATCH);
  assign operand_a = a_q;
  assign operand_b = b_q;
  assign overflow  = ovf_q;
  assign error     = (state_q == S_ERROR);
  assign busy      = (state_q == S_DISPATCH) || (state_q == S_WAIT_RES);
  assign state     = state_q;

endmodule

// File: tb/tb_calc_sequencer_p.sv
// tb/tb_calc_sequencer_p.sv - self-checking bench for calc_sequencer_p
module tb_calc_sequencer_p;

  localparam int DIGITS = 8;
  localparam int W      = 28;
  localparam int NOPS   = 7;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                key_valid = 1'b0;
  logic [4:0]          key_code = '0;
  logic [NOPS-1:0]     op_sel;
  logic                op_start;
  logic signed [W-1:0] operand_a, operand_b, display;
  logic                res_valid = 1'b0;
  logic signed [W-1:0] res_data = '0;
  logic                res_err = 1'b0;
  logic                overflow, error, busy;
  logic [3:0]          state;

  int n_cmp = 0;
  int n_bad = 0;
  int hold_stuck = 0;

  calc_sequencer_p #(.DIGITS(DIGITS), .W(W), .HOLD_W(2), .TMO_W(4), .NOPS(NOPS)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .op_sel(op_sel), .op_start(op_start), .operand_a(operand_a), .operand_b(operand_b),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .display(display), .overflow(overflow), .error(error), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [NOPS-1:0] op_bits(input int code);
    case (code)
      11: return 7'b1000000;
      12: return 7'b0100000;
      13: return 7'b0010000;
      14: return 7'b0001000;
      15: return 7'b0000100;
      16: return 7'b0000010;
      17: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference editing of an operand as a plain integer.
  task automatic model_key(inout longint v, inout int c, input int code);
    if (code <= 9) begin
      if (c < DIGITS) begin
        if (!(v == 0 && code == 0)) c++;
        v = (v < 0) ? v * 10 - code : v * 10 + code;
      end
    end else if (code == 19) begin
      v = v / 10;
      if (c > 0) c--;
    end else if (code == 20) begin
      v = -v;
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic press(input int code);
    key_valid = 1'b1;
    key_code  = 5'(code);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press_wait(input int code);
    int n;
    press(code);
    n = 0;
    while ((state == 4'd2 || state == 4'd4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) hold_stuck++;
  endtask

  task automatic esc();
    press(18);
    @(negedge clk);
  endtask

  task automatic unit_respond(input logic signed [W-1:0] data, input bit err,
                              input int delay, output int starts);
    int n;
    starts = 0;
    n = 0;
    while (!op_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < delay; i++) begin
      if (op_start) starts++;
      @(negedge clk);
    end
    res_valid = 1'b1;
    res_data  = data;
    res_err   = err;
    @(negedge clk);
    res_valid = 1'b0;
    res_err   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if ({op_sel, op_start, overflow, error, busy} !== '0) begin n_bad++; $display("FAIL reset_flags got %b want 0", {op_sel, op_start, overflow, error, busy}); end
    n_cmp++; if (operand_a !== 0 || operand_b !== 0 || display !== 0) begin n_bad++; $display("FAIL reset_values got %0d/%0d/%0d want 0/0/0", operand_a, operand_b, display); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (state !== 4'd1) begin n_bad++; $display("FAIL reset_to_entry got %0d want 1", state); end
  endtask

  task automatic test_basic();
    int hc, starts;
    press(1);
    hc = 0;
    while (state == 4'd2 && hc < 20) begin @(negedge clk); hc++; end
    n_cmp++; if (hc !== 4) begin n_bad++; $display("FAIL hold_cycles got %0d want 4", hc); end
    press_wait(2); press_wait(3); press(11);
    n_cmp++; if (state !== 4'd3) begin n_bad++; $display("FAIL basic_entry_b got %0d want 3", state); end
    press_wait(4); press_wait(5);
    n_cmp++; if (display !== 45) begin n_bad++; $display("FAIL basic_disp_b got %0d want 45", display); end
    press(10);
    n_cmp++; if (state !== 4'd5 || op_start !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_dispatch got %0d/%b/%b want 5/1/1", state, op_start, busy); end
    unit_respond(28'sd168, 1'b0, 3, starts);
    n_cmp++; if (starts !== 1) begin n_bad++; $display("FAIL basic_starts got %0d want 1", starts); end
    n_cmp++; if (operand_a !== 123 || operand_b !== 45) begin n_bad++; $display("FAIL basic_operands got %0d/%0d want 123/45", operand_a, operand_b); end
    n_cmp++; if (op_sel !== 7'b1000000) begin n_bad++; $display("FAIL basic_op_sel got %b want 1000000", op_sel); end
    n_cmp++; if (display !== 168 || state !== 4'd7 || overflow !== 1'b0) begin n_bad++; $display("FAIL basic_show got %0d/%0d/%b want 168/7/0", display, state, overflow); end
  endtask

  task automatic test_chain();
    int starts;
    press(13); press_wait(2); press(10);
    unit_respond(28'sd336, 1'b0, 2, starts);
    n_cmp++; if (operand_a !== 168 || operand_b !== 2) begin n_bad++; $display("FAIL chain_operands got %0d/%0d want 168/2", operand_a, operand_b); end
    n_cmp++; if (display !== 336 || state !== 4'd7 || op_sel !== 7'b0010000) begin n_bad++; $display("FAIL chain_show got %0d/%0d/%b want 336/7/0010000", display, state, op_sel); end
  endtask

  task automatic test_digit_limit();
    esc();
    repeat (9) press_wait(9);
    n_cmp++; if (operand_a !== 99999999 || state !== 4'd1) begin n_bad++; $display("FAIL limit_nine got %0d/%0d want 99999999/1", operand_a, state); end
    press(19);
    n_cmp++; if (operand_a !== 9999999) begin n_bad++; $display("FAIL limit_back got %0d want 9999999", operand_a); end
    press(20);
    n_cmp++; if (operand_a !== -9999999) begin n_bad++; $display("FAIL limit_neg got %0d want -9999999", operand_a); end
    press_wait(5);
    n_cmp++; if (operand_a !== -99999995) begin n_bad++; $display("FAIL limit_neg_digit got %0d want -99999995", operand_a); end
    esc();
    press(20);
    n_cmp++; if (operand_a !== 0) begin n_bad++; $display("FAIL neg_zero got %0d want 0", operand_a); end
    repeat (3) press_wait(0);
    repeat (9) press_wait(1);
    n_cmp++; if (operand_a !== 11111111) begin n_bad++; $display("FAIL leading_zero got %0d want 11111111", operand_a); end
  endtask

  task automatic test_overflow();
    int starts;
    esc();
    press_wait(5); press(11); press_wait(6); press(10);
    unit_respond(28'sd100000000, 1'b0, 2, starts);
    n_cmp++; if (overflow !== 1'b1 || error !== 1'b1 || state !== 4'd8) begin n_bad++; $display("FAIL ovf_error got %b/%b/%0d want 1/1/8", overflow, error, state); end
    press(3);
    n_cmp++; if (state !== 4'd8 || operand_a !== 5) begin n_bad++; $display("FAIL ovf_digit_ignored got %0d/%0d want 8/5", state, operand_a); end
    press(18);
    n_cmp++; if (state !== 4'd0 || overflow !== 0 || error !== 0 || display !== 0 || operand_a !== 0 || op_sel !== 0) begin n_bad++; $display("FAIL ovf_escape got %0d/%b/%b/%0d/%0d/%b want 0/0/0/0/0/0", state, overflow, error, display, operand_a, op_sel); end
    @(negedge clk);
    n_cmp++; if (state !== 4'd1) begin n_bad++; $display("FAIL ovf_reentry got %0d want 1", state); end
  endtask

  task automatic test_timeout();
    int n;
    esc();
    press_wait(2); press(17);
    @(negedge clk);
    n = 0;
    while (state == 4'd6 && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL tmo_cycles got %0d want 16", n); end
    n_cmp++; if (state !== 4'd8 || overflow !== 1'b1) begin n_bad++; $display("FAIL tmo_error got %0d/%b want 8/1", state, overflow); end
    res_valid = 1'b1; res_data = 28'sd55;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (display !== 0 || state !== 4'd8) begin n_bad++; $display("FAIL tmo_late_res got %0d/%0d want 0/8", display, state); end
  endtask

  task automatic test_escape_vs_res();
    esc();
    press_wait(4); press(15);
    @(negedge clk);
    n_cmp++; if (state !== 4'd6) begin n_bad++; $display("FAIL esc_res_wait got %0d want 6", state); end
    key_valid = 1'b1; key_code = 5'd18; res_valid = 1'b1; res_data = 28'sd77;
    @(negedge clk);
    key_valid = 1'b0; res_valid = 1'b0;
    n_cmp++; if (state !== 4'd0 || display !== 0 || overflow !== 0) begin n_bad++; $display("FAIL esc_res got %0d/%0d/%b want 0/0/0", state, display, overflow); end
    @(negedge clk);
  endtask

  task automatic test_reset_hold_b();
    int starts;
    esc();
    press_wait(1); press(12); press(3);
    n_cmp++; if (state !== 4'd4) begin n_bad++; $display("FAIL rst_hold_b_state got %0d want 4", state); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({state, op_sel, op_start, overflow, error, busy} !== '0 || operand_a !== 0 || operand_b !== 0 || display !== 0) begin n_bad++; $display("FAIL rst_hold_b got st=%0d sel=%b a=%0d b=%0d d=%0d want all 0", state, op_sel, operand_a, operand_b, display); end
    rst = 1'b0;
    starts = 0;
    repeat (25) begin @(negedge clk); if (op_start) starts++; end
    n_cmp++; if (starts !== 0 || state !== 4'd1) begin n_bad++; $display("FAIL rst_no_start got %0d/%0d want 0/1", starts, state); end
  endtask

  task automatic test_random();
    longint va, vb, rv;
    int ca, cb, code, op, starts;
    bit err, bad;
    for (int it = 0; it < 40; it++) begin
      esc();
      va = 0; ca = 0;
      repeat ($urandom_range(1, 12)) begin
        case ($urandom_range(0, 9))
          7: code = 19;
          8: code = 20;
          default: code = $urandom_range(0, 9);
        endcase
        model_key(va, ca, code);
        press_wait(code);
      end
      n_cmp++; if (operand_a !== W'(va)) begin n_bad++; $display("FAIL rand_a it=%0d got %0d want %0d", it, operand_a, va); end
      op = $urandom_range(11, 17);
      press(op);
      vb = 0;
      if (op == 15 || op == 17) begin
        n_cmp++; if (state !== 4'd5) begin n_bad++; $display("FAIL rand_unary it=%0d got %0d want 5", it, state); end
      end else begin
        cb = 0;
        repeat ($urandom_range(0, 10)) begin
          code = ($urandom_range(0, 4) == 0) ? 19 : $urandom_range(0, 9);
          model_key(vb, cb, code);
          press_wait(code);
        end
        n_cmp++; if (operand_b !== W'(vb) || state !== 4'd3) begin n_bad++; $display("FAIL rand_b it=%0d got %0d/%0d want %0d/3", it, operand_b, state, vb); end
        press(10);
      end
      rv = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 134217727)) : longint'($urandom_range(0, 99999999));
      if ($urandom_range(0, 1) == 1) rv = -rv;
      err = ($urandom_range(0, 7) == 0);
      bad = err || rv > 99999999 || rv < -99999999;
      unit_respond(W'(rv), err, $urandom_range(1, 5), starts);
      n_cmp++; if (starts !== 1 || display !== W'(rv)) begin n_bad++; $display("FAIL rand_res it=%0d got %0d/%0d want 1/%0d", it, starts, display, rv); end
      n_cmp++; if (state !== (bad ? 4'd8 : 4'd7) || overflow !== bad) begin n_bad++; $display("FAIL rand_status it=%0d got %0d/%b want %0d/%b", it, state, overflow, bad ? 8 : 7, bad); end
      n_cmp++; if (op_sel !== op_bits(op) || operand_a !== W'(va) || operand_b !== W'(vb)) begin n_bad++; $display("FAIL rand_latched it=%0d got %b/%0d/%0d want %b/%0d/%0d", it, op_sel, operand_a, operand_b, op_bits(op), va, vb); end
    end
    n_cmp++; if (hold_stuck !== 0) begin n_bad++; $display("FAIL hold_exit got %0d stuck want 0", hold_stuck); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_basic();
    test_chain();
    test_digit_limit();
    test_overflow();
    test_timeout();
    test_escape_vs_res();
    test_reset_hold_b();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
